// File: rtl/hdlc_pkg.sv
// Shared HDLC receive constants and the deframer state type.
package hdlc_pkg;

   // Flag 0111_1110; arrives LSB first as 0,1,1,1,1,1,1,0.
   localparam logic [7:0] HDLC_FLAG      = 8'h7E;
   // Abort: a 0 followed by seven 1s (LSB first 0,1,1,1,1,1,1,1).
   localparam logic [7:0] HDLC_ABORT     = 8'hFE;
   // Run of 1s after which the transmitter inserts a 0.
   localparam logic [2:0] STUFF_ONES     = 3'd5;
   // Flag bits still queued in the data path when the flag is acted upon.
   localparam logic [2:0] FLAG_TAIL_BITS = 3'd7;

   typedef enum logic {
      HUNT  = 1'b0,
      FRAME = 1'b1
   } hdlc_rx_state_t;

endpackage

// File: rtl/hdlc_rx_pattern_detect.sv
// Receive window: 8-bit LSB-first shift register, registered flag/abort
// match, and a one-bit delay on the bit leaving the window so the data path
// lags detection by one cycle.
module hdlc_rx_pattern_detect
   import hdlc_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic rx,
   output logic flag_detect,
   output logic abort_detect,
   output logic line_bit
);

   // window[0] is the oldest bit, window[7] the newest.
   logic [7:0] window;

   // Shift the line into the window and register the pattern matches.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values present before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         window       <= '1;
         line_bit     <= 1'b1;
         flag_detect  <= 1'b0;
         abort_detect <= 1'b0;
      end else if (!enable) begin
         window       <= '1;
         line_bit     <= 1'b1;
         flag_detect  <= 1'b0;
         abort_detect <= 1'b0;
      end else begin
         window       <= {rx, window[7:1]};
         line_bit     <= window[0];
         flag_detect  <= (window == HDLC_FLAG);
         abort_detect <= (window == HDLC_ABORT);
      end
   end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: frame FSM, zero removal, LSB-first byte assembly
// and the registered Rx control strobes.
module hdlc_rx_deframer
   import hdlc_pkg::*;
#(
   parameter int unsigned MIN_FRAME_BYTES = 1
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Rx,
   input  logic       Rx_Enable,
   output logic       Rx_FlagDetect,
   output logic       Rx_AbortDetect,
   output logic       Rx_ValidFrame,
   output logic       Rx_AbortSignal,
   output logic [7:0] Rx_Data,
   output logic       Rx_WrBuff,
   output logic       Rx_EoF,
   output logic       Rx_FrameError
);

   localparam logic [7:0] MIN_BYTES = 8'(MIN_FRAME_BYTES);

   hdlc_rx_state_t state, state_next;

   logic       line_bit;
   logic       frame_start, eof_next, ferr_next, abort_next, data_en;
   logic       keep_bit, byte_done;
   logic [2:0] ones_cnt, bit_cnt, skip_cnt;
   logic [7:0] byte_cnt, byte_sr;

   hdlc_rx_pattern_detect u_detect (
      .clk          (Clk),
      .rst_n        (Rst),
      .enable       (Rx_Enable),
      .rx           (Rx),
      .flag_detect  (Rx_FlagDetect),
      .abort_detect (Rx_AbortDetect),
      .line_bit     (line_bit)
   );

   // Frame state register; disabling the receiver drops back to HUNT.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)            state <= HUNT;
      else if (!Rx_Enable) state <= HUNT;
      else                 state <= state_next;
   end

   assign Rx_ValidFrame = (state == FRAME);

   // Next state and next-cycle strobe decisions from the detector pulses.
   // NOTE: every signal gets its default first so no latch is inferred.
   always_comb begin
      state_next  = state;
      frame_start = 1'b0;
      eof_next    = 1'b0;
      ferr_next   = 1'b0;
      abort_next  = 1'b0;
      data_en     = 1'b0;
      case (state)
         HUNT: begin
            if (Rx_FlagDetect) begin
               state_next  = FRAME;
               frame_start = 1'b1;
            end
         end
         FRAME: begin
            if (Rx_AbortDetect) begin
               state_next = HUNT;
               abort_next = 1'b1;
            end else if (Rx_FlagDetect) begin
               // Closing flag doubles as the opening flag of the next frame.
               frame_start = 1'b1;
               if (byte_cnt == MIN_BYTES) begin
                  eof_next  = 1'b1;
                  ferr_next = (bit_cnt != 3'd0);
               end
            end else begin
               // Bits of the flag that opened this frame are still draining.
               data_en = (skip_cnt == 3'd0);
            end
         end
         default: state_next = HUNT;
      endcase
   end

   // A 0 after five 1s is a stuffed bit and is dropped.
   assign keep_bit  = data_en && !(!line_bit && (ones_cnt == STUFF_ONES));
   assign byte_done = keep_bit && (bit_cnt == 3'd7);

   // Zero removal, byte shift register and the frame counters.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ones_cnt <= '0;
         bit_cnt  <= '0;
         skip_cnt <= '0;
         byte_cnt <= '0;
         byte_sr  <= '0;
      end else if (!Rx_Enable || (state_next == HUNT)) begin
         ones_cnt <= '0;
         bit_cnt  <= '0;
         skip_cnt <= '0;
         byte_cnt <= '0;
         byte_sr  <= '0;
      end else if (frame_start) begin
         ones_cnt <= '0;
         bit_cnt  <= '0;
         skip_cnt <= FLAG_TAIL_BITS;
         byte_cnt <= '0;
      end else begin
         if (skip_cnt != 3'd0) skip_cnt <= skip_cnt - 1'b1;
         if (data_en) begin
            if (line_bit) ones_cnt <= (ones_cnt == 3'd7) ? ones_cnt : ones_cnt + 1'b1;
            else          ones_cnt <= '0;
         end
         if (keep_bit) begin
            byte_sr <= {line_bit, byte_sr[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            // Only "at least MIN_BYTES" matters, so the count saturates.
            if (byte_done && (byte_cnt != MIN_BYTES)) byte_cnt <= byte_cnt + 1'b1;
         end
      end
   end

   // Registered output strobes and the assembled byte.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         Rx_WrBuff      <= 1'b0;
         Rx_EoF         <= 1'b0;
         Rx_FrameError  <= 1'b0;
         Rx_AbortSignal <= 1'b0;
         Rx_Data        <= 8'h00;
      end else if (!Rx_Enable) begin
         Rx_WrBuff      <= 1'b0;
         Rx_EoF         <= 1'b0;
         Rx_FrameError  <= 1'b0;
         Rx_AbortSignal <= 1'b0;
         Rx_Data        <= 8'h00;
      end else begin
         Rx_WrBuff      <= byte_done;
         Rx_EoF         <= eof_next;
         Rx_FrameError  <= ferr_next;
         Rx_AbortSignal <= abort_next;
         if (byte_done) Rx_Data <= {line_bit, byte_sr[7:1]};
      end
   end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Self-checking bench for hdlc_rx_deframer: a frame-level reference model
// queues expected writes, end-of-frame and abort events; an independent
// monitor pops and compares them as the DUT raises its strobes.
module tb_hdlc_rx_deframer;

   localparam int MIN_BYTES = 1;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       Rx = 1'b1;
   logic       Rx_Enable = 1'b0;
   logic       Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal;
   logic [7:0] Rx_Data;
   logic       Rx_WrBuff, Rx_EoF, Rx_FrameError;

   hdlc_rx_deframer #(.MIN_FRAME_BYTES(MIN_BYTES)) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .Rx             (Rx),
      .Rx_Enable      (Rx_Enable),
      .Rx_FlagDetect  (Rx_FlagDetect),
      .Rx_AbortDetect (Rx_AbortDetect),
      .Rx_ValidFrame  (Rx_ValidFrame),
      .Rx_AbortSignal (Rx_AbortSignal),
      .Rx_Data        (Rx_Data),
      .Rx_WrBuff      (Rx_WrBuff),
      .Rx_EoF         (Rx_EoF),
      .Rx_FrameError  (Rx_FrameError)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc++;

   typedef enum int {EV_BYTE, EV_EOF, EV_ABORT} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
      logic       ferr;
   } ev_t;

   ev_t exp_q[$];

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   bit         m_in_frame = 1'b0;
   int         m_nbits    = 0;
   logic [7:0] m_acc      = 8'h00;
   int         flags_exp  = 0;
   int         aborts_exp = 0;
   int         stuff_ones = 0;
   int         last_edge  = 0;

   task automatic push_ev(input ev_kind_t k, input logic [7:0] d, input logic f);
      ev_t e;
      e.kind = k;
      e.data = d;
      e.ferr = f;
      exp_q.push_back(e);
   endtask

   task automatic send_bit(input logic b);
      @(negedge Clk);
      Rx = b;
      last_edge = cyc + 1;
   endtask

   task automatic send_raw(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic send_flag();
      if (m_in_frame && ((m_nbits / 8) >= MIN_BYTES))
         push_ev(EV_EOF, 8'h00, (m_nbits % 8) != 0);
      m_in_frame = 1'b1;
      m_nbits    = 0;
      stuff_ones = 0;
      flags_exp++;
      send_raw(8'h7E);
   endtask

   task automatic send_abort();
      aborts_exp++;
      if (m_in_frame) push_ev(EV_ABORT, 8'h00, 1'b0);
      m_in_frame = 1'b0;
      m_nbits    = 0;
      stuff_ones = 0;
      send_raw(8'hFE);
   endtask

   task automatic send_idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   // One payload bit: model it, send it, and insert a stuffed 0 when due.
   task automatic send_data_bit(input logic b);
      m_acc = {b, m_acc[7:1]};
      m_nbits++;
      if ((m_nbits % 8) == 0) push_ev(EV_BYTE, m_acc, 1'b0);
      send_bit(b);
      if (b) begin
         stuff_ones++;
         if (stuff_ones == 5) begin
            send_bit(1'b0);
            stuff_ones = 0;
         end
      end else begin
         stuff_ones = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_data_bit(v[i]);
   endtask

   task automatic check_quiet(input string name);
      check(name, {Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal,
                   Rx_WrBuff, Rx_EoF, Rx_FrameError, Rx_Data}, 32'h0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   int   n_flag = 0, n_abort = 0;
   int   last_flag_edge = -100, last_abort_edge = -100, valid_rise_edge = -100;
   logic prev_valid = 1'b0;
   ev_t  mon_ev;
   bit   mon_ok;

   task automatic take_event(output ev_t e, output bit ok);
      check("event_expected", exp_q.size() != 0, 1);
      ok = (exp_q.size() != 0);
      if (ok) e = exp_q.pop_front();
      else    e = '{EV_BYTE, 8'h00, 1'b0};
   endtask

   always @(negedge Clk) begin
      if (Rst) begin
         if (Rx_FlagDetect) begin
            n_flag++;
            last_flag_edge = cyc;
         end
         if (Rx_AbortDetect) begin
            n_abort++;
            last_abort_edge = cyc;
         end
         if (Rx_ValidFrame && !prev_valid) valid_rise_edge = cyc;
         if (Rx_WrBuff) begin
            take_event(mon_ev, mon_ok);
            if (mon_ok) begin
               check("wrbuff_kind", mon_ev.kind, EV_BYTE);
               if (mon_ev.kind == EV_BYTE) check("rx_data", Rx_Data, mon_ev.data);
            end
         end
         if (Rx_EoF) begin
            take_event(mon_ev, mon_ok);
            check("eof_timing", cyc, last_flag_edge + 1);
            if (mon_ok) begin
               check("eof_kind", mon_ev.kind, EV_EOF);
               check("frame_error", Rx_FrameError, mon_ev.ferr);
            end
         end
         if (Rx_FrameError) check("frame_error_with_eof", Rx_EoF, 1);
         if (Rx_AbortSignal) begin
            take_event(mon_ev, mon_ok);
            check("abort_signal_timing", cyc, last_abort_edge + 1);
            check("valid_low_with_abort_signal", Rx_ValidFrame, 0);
            if (mon_ok) check("abort_kind", mon_ev.kind, EV_ABORT);
         end
      end
      prev_valid = Rx_ValidFrame;
   end

   // ---------------- stimulus ----------------
   initial begin
      int         fl, ab, nbytes, extra;
      logic [7:0] v;

      // Reset state
      Rx_Enable = 1'b1;
      repeat (3) @(posedge Clk);
      #1 check_quiet("reset_outputs");
      @(negedge Clk) Rst = 1'b1;
      repeat (3) @(posedge Clk);
      #1 check_quiet("post_reset_idle");

      // Idle then opening flag: detection latency and ValidFrame rise
      send_idle(10);
      send_flag();
      fl = last_edge;
      send_byte(8'hA5);
      check("flag_detect_latency", last_flag_edge, fl + 1);
      check("valid_frame_rise", valid_rise_edge, fl + 2);
      check("valid_in_frame", Rx_ValidFrame, 1);
      send_byte(8'h3C);
      send_flag();

      // Byte needing a stuffed zero
      send_byte(8'h1F);
      send_flag();

      // Byte then abort
      send_byte(8'h55);
      send_abort();
      ab = last_edge;
      send_idle(4);
      check("abort_detect_latency", last_abort_edge, ab + 1);
      check("valid_after_abort", Rx_ValidFrame, 0);

      // 12 data bits: one byte written, closing flag misaligned
      send_flag();
      for (int i = 0; i < 12; i++) send_data_bit(1'($urandom()));
      send_flag();

      // Randomized frames
      for (int f = 0; f < 25; f++) begin
         nbytes = $urandom_range(0, 3);
         extra  = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7);
         if (!m_in_frame) begin
            send_idle($urandom_range(0, 12));
            send_flag();
         end
         for (int b = 0; b < nbytes; b++) begin
            v = 8'($urandom());
            send_byte(v);
         end
         for (int b = 0; b < extra; b++) send_data_bit(1'($urandom()));
         if ($urandom_range(0, 4) == 0) send_abort();
         else                           send_flag();
      end

      // Receiver disabled mid-frame: back to HUNT, outputs 0, no EoF
      if (!m_in_frame) send_flag();
      for (int i = 0; i < 5; i++) send_data_bit(1'($urandom()));
      @(negedge Clk);
      Rx_Enable  = 1'b0;
      Rx         = 1'b1;
      m_in_frame = 1'b0;
      m_nbits    = 0;
      stuff_ones = 0;
      @(posedge Clk);
      #1 check_quiet("disable_outputs");
      repeat (5) @(posedge Clk);
      #1 check_quiet("disabled_hold");
      @(negedge Clk) Rx_Enable = 1'b1;
      send_idle(12);
      send_flag();
      send_byte(8'hC3);
      send_flag();

      // Asynchronous reset mid-byte
      for (int i = 0; i < 4; i++) send_data_bit(1'($urandom()));
      @(negedge Clk);
      Rst        = 1'b0;
      Rx         = 1'b1;
      m_in_frame = 1'b0;
      m_nbits    = 0;
      stuff_ones = 0;
      #1 check_quiet("async_reset_immediate");
      repeat (3) @(negedge Clk);
      Rst = 1'b1;
      send_idle(20);
      check("flags_after_reset_idle", n_flag, flags_exp);
      check("valid_after_reset_idle", Rx_ValidFrame, 0);

      // Recovery frame, then abort to leave the line idle
      send_flag();
      v = 8'($urandom());
      send_byte(v);
      v = 8'($urandom());
      send_byte(v);
      send_flag();
      send_abort();
      send_idle(2);

      for (int i = 0; (i < 40) && (exp_q.size() != 0); i++) @(negedge Clk);
      repeat (3) @(negedge Clk);
      check("scoreboard_drained", exp_q.size(), 0);
      check("flag_detect_count", n_flag, flags_exp);
      check("abort_detect_count", n_abort, aborts_exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
